// File: rtl/bru_pipe_pkg.sv
// Shared definitions for the pipelined branch resolution unit.
//   br_ctrl_e  : issue control encodings (branch kind / jalr / illegal)
//   *_DEF      : default widths used by the interface and modules
package bru_pipe_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned ROB_W_DEF = 6;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    BR_BEQ     = 3'b000,
    BR_BNE     = 3'b001,
    BR_JALR    = 3'b010,
    BR_ILLEGAL = 3'b011,
    BR_BLT     = 3'b100,
    BR_BGE     = 3'b101,
    BR_BLTU    = 3'b110,
    BR_BGEU    = 3'b111
  } br_ctrl_e;

endpackage

// File: rtl/bru_pipe_if.sv
// Issue/result handshake bundle of bru_pipe.
//   in_*  : issued branch (valid/ready, ROB tag, ctrl, operands, pc, prediction)
//   out_* : resolved result (valid/ready, ROB tag, direction, mispredict, redirect, illegal)
// master = issuer/consumer side, slave = the branch unit.
interface bru_pipe_if
  import bru_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned ROB_W = ROB_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [ROB_W-1:0] in_tag;
  logic [2:0]       in_ctrl;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [XLEN-1:0]  in_pc;
  logic             in_pre_dir;
  logic [XLEN-1:0]  in_pre_addr;

  logic             out_valid;
  logic             out_ready;
  logic [ROB_W-1:0] out_tag;
  logic             out_taken;
  logic             out_mispred;
  logic [XLEN-1:0]  out_redirect;
  logic             out_illegal;

  modport master (
    output in_valid, in_tag, in_ctrl, in_a, in_b, in_pc, in_pre_dir, in_pre_addr, out_ready,
    input  in_ready, out_valid, out_tag, out_taken, out_mispred, out_redirect, out_illegal
  );

  modport slave (
    input  in_valid, in_tag, in_ctrl, in_a, in_b, in_pc, in_pre_dir, in_pre_addr, out_ready,
    output in_ready, out_valid, out_tag, out_taken, out_mispred, out_redirect, out_illegal
  );
endinterface

// File: rtl/bru_resolve.sv
// Combinational branch resolution: direction, target and mispredict check.
//   ctrl, a, b, pc, pre_dir, pre_addr : latched issue fields
//   taken, mispred, redirect, illegal : resolved result
module bru_resolve
  import bru_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [2:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic            pre_dir,
  input  logic [XLEN-1:0] pre_addr,
  output logic            taken,
  output logic            mispred,
  output logic [XLEN-1:0] redirect,
  output logic            illegal
);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthrough;
  logic            cond;
  logic            is_cond_br;

  always_comb begin
    // jalr target keeps every upper bit; only bit 0 is cleared
    target      = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
    fallthrough = pc + XLEN'(4);
    cond        = 1'b0;
    is_cond_br  = 1'b1;
    taken       = 1'b0;
    mispred     = 1'b0;
    redirect    = fallthrough;
    illegal     = 1'b0;

    unique case (br_ctrl_e'(ctrl))
      BR_BEQ:     cond = (a == b);
      BR_BNE:     cond = (a != b);
      BR_BLT:     cond = ($signed(a) <  $signed(b));
      BR_BGE:     cond = ($signed(a) >= $signed(b));
      BR_BLTU:    cond = (a <  b);
      BR_BGEU:    cond = (a >= b);
      BR_JALR:    is_cond_br = 1'b0;
      BR_ILLEGAL: is_cond_br = 1'b0;
    endcase

    if (is_cond_br) begin
      taken    = cond;
      mispred  = (cond != pre_dir);
      redirect = cond ? pre_addr : fallthrough;
    end else if (br_ctrl_e'(ctrl) == BR_JALR) begin
      taken    = 1'b1;
      mispred  = !pre_dir || (target != pre_addr);
      redirect = target;
    end else begin
      mispred  = 1'b1;
      illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/bru_pipe.sv
// Pipelined branch resolution unit: S1 latches the issued op, S2 holds the
// resolved result until the consumer takes it.
//   clk, rst (sync, active-high), flush : control
//   bus (slave)                         : issue and result handshakes
//   perf_branches, perf_mispred         : delivered / mispredicted result counts
module bru_pipe
  import bru_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned ROB_W = ROB_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  bru_pipe_if.slave        bus,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispred
);

  logic             s1_valid;
  logic [ROB_W-1:0] s1_tag;
  logic [2:0]       s1_ctrl;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [XLEN-1:0]  s1_pc;
  logic             s1_pre_dir;
  logic [XLEN-1:0]  s1_pre_addr;

  logic             s2_valid;
  logic [ROB_W-1:0] s2_tag;
  logic             s2_taken;
  logic             s2_mispred;
  logic [XLEN-1:0]  s2_redirect;
  logic             s2_illegal;

  logic             res_taken;
  logic             res_mispred;
  logic [XLEN-1:0]  res_redirect;
  logic             res_illegal;

  logic adv1;
  logic adv2;
  logic accept;
  logic deliver;

  bru_resolve #(.XLEN(XLEN)) u_resolve (
    .ctrl     (s1_ctrl),
    .a        (s1_a),
    .b        (s1_b),
    .pc       (s1_pc),
    .pre_dir  (s1_pre_dir),
    .pre_addr (s1_pre_addr),
    .taken    (res_taken),
    .mispred  (res_mispred),
    .redirect (res_redirect),
    .illegal  (res_illegal)
  );

  always_comb begin
    adv2    = !s2_valid || bus.out_ready;
    adv1    = !s1_valid || adv2;
    accept  = bus.in_valid && adv1 && !flush;
    deliver = s2_valid && bus.out_ready;
  end

  assign bus.in_ready     = adv1;
  assign bus.out_valid    = s2_valid;
  assign bus.out_tag      = s2_tag;
  assign bus.out_taken    = s2_taken;
  assign bus.out_mispred  = s2_mispred;
  assign bus.out_redirect = s2_redirect;
  assign bus.out_illegal  = s2_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_tag        <= '0;
      s1_ctrl       <= '0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_pc         <= '0;
      s1_pre_dir    <= 1'b0;
      s1_pre_addr   <= '0;
      s2_valid      <= 1'b0;
      s2_tag        <= '0;
      s2_taken      <= 1'b0;
      s2_mispred    <= 1'b0;
      s2_redirect   <= '0;
      s2_illegal    <= 1'b0;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      // A result handed over in the flush cycle was still delivered, so it counts.
      if (deliver) begin
        perf_branches <= perf_branches + CNT_W'(1);
        if (s2_mispred) perf_mispred <= perf_mispred + CNT_W'(1);
      end

      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (adv1) begin
          s1_valid <= accept;
          if (accept) begin
            s1_tag      <= bus.in_tag;
            s1_ctrl     <= bus.in_ctrl;
            s1_a        <= bus.in_a;
            s1_b        <= bus.in_b;
            s1_pc       <= bus.in_pc;
            s1_pre_dir  <= bus.in_pre_dir;
            s1_pre_addr <= bus.in_pre_addr;
          end
        end
        // S2 payload only changes when it advances, keeping out_* stable under stall
        if (adv2) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_tag      <= s1_tag;
            s2_taken    <= res_taken;
            s2_mispred  <= res_mispred;
            s2_redirect <= res_redirect;
            s2_illegal  <= res_illegal;
          end
        end
      end
    end
  end

endmodule
